// File: rtl/multi_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_clk_divider
// Purpose  : Multi-channel programmable 50%-duty clock divider with tick
//            outputs and glitch-free reload of the half-period.
// Revision : 1.0
// ============================================================================
module multi_clk_divider #(
  parameter int CH           = 2,
  parameter int CNT_W        = 25,
  parameter int DEFAULT_HALF = 25000000
) (
  input  logic                                    clk_in,
  input  logic                                    reset,
  input  logic [CH-1:0]                           en,
  input  logic                                    load,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  load_ch,
  input  logic [CNT_W-1:0]                        load_half,
  output logic                                    load_err,
  output logic [CH-1:0]                           pending,
  output logic [CH-1:0]                           clk_out,
  output logic [CH-1:0]                           tick
);

  localparam int               c_SEL_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] c_DEFAULT = CNT_W'(DEFAULT_HALF);
  localparam logic [c_SEL_W:0] c_CH      = (c_SEL_W + 1)'(CH);

  logic w_load_ok;
  logic w_load_bad;
  logic r_load_err;

  // Extra MSB lets the range test work even when CH is a power of two.
  assign w_load_ok  = load && (load_half != '0) && ({1'b0, load_ch} < c_CH);
  assign w_load_bad = load && !w_load_ok;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_load_bad;
    end
  end

  assign load_err = r_load_err;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_nxt;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic             w_sel;
    logic             w_wrap;

    assign w_sel  = w_load_ok && (load_ch == c_SEL_W'(g));
    assign w_wrap = en[g] && (r_cnt == r_half - 1'b1);

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_half <= c_DEFAULT;
        r_nxt  <= c_DEFAULT;
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (!en[g]) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end

        // Staged value is consumed with the old flag; a same-edge load re-arms it.
        if (r_pend && (!en[g] || w_wrap)) begin
          r_half <= r_nxt;
        end
        if (w_sel) begin
          r_nxt  <= load_half;
          r_pend <= 1'b1;
        end else if (!en[g] || w_wrap) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign pending[g] = r_pend;
    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_clk_divider
// Purpose  : Scoreboard bench for multi_clk_divider (CH=2, CNT_W=8, H=4),
//            plus a CH=3 instance for out-of-range channel loads.
// Revision : 1.0
// ============================================================================
module tb_multi_clk_divider;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic       load;
  logic [0:0] load_ch;
  logic [7:0] load_half;
  logic       load_err;
  logic [1:0] pending;
  logic [1:0] clk_out;
  logic [1:0] tick;

  logic [2:0] en3;
  logic       load3;
  logic [1:0] load_ch3;
  logic [7:0] load_half3;
  logic       load_err3;
  logic [2:0] pending3;
  logic [2:0] clk_out3;
  logic [2:0] tick3;

  always #5 clk_in = ~clk_in;

  multi_clk_divider #(.CH(2), .CNT_W(8), .DEFAULT_HALF(4)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .load(load), .load_ch(load_ch),
    .load_half(load_half), .load_err(load_err), .pending(pending),
    .clk_out(clk_out), .tick(tick)
  );

  multi_clk_divider #(.CH(3), .CNT_W(8), .DEFAULT_HALF(4)) dut3 (
    .clk_in(clk_in), .reset(reset), .en(en3), .load(load3), .load_ch(load_ch3),
    .load_half(load_half3), .load_err(load_err3), .pending(pending3),
    .clk_out(clk_out3), .tick(tick3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of the two-channel instance.
  typedef struct packed {
    logic       err;
    logic [1:0] pend;
    logic [1:0] clk;
    logic [1:0] tck;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_cnt  [2];
  logic [7:0] m_half [2];
  logic [7:0] m_nxt  [2];
  logic [1:0] m_pend, m_clk, m_tick;
  logic       m_err;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 8'd0; m_half[c] = 8'd4; m_nxt[c] = 8'd4;
    end
    m_pend = '0; m_clk = '0; m_tick = '0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic bad;
    bad   = load && (load_half == 8'd0);
    m_err = bad;
    for (int c = 0; c < 2; c++) begin
      if (!en[c]) begin
        m_cnt[c] = 8'd0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
        if (m_pend[c]) begin m_half[c] = m_nxt[c]; m_pend[c] = 1'b0; end
      end else if (m_cnt[c] == m_half[c] - 8'd1) begin
        m_cnt[c]  = 8'd0;
        m_tick[c] = !m_clk[c];
        m_clk[c]  = !m_clk[c];
        if (m_pend[c]) begin m_half[c] = m_nxt[c]; m_pend[c] = 1'b0; end
      end else begin
        m_cnt[c]  = m_cnt[c] + 8'd1;
        m_tick[c] = 1'b0;
      end
      if (load && !bad && (int'(load_ch) == c)) begin
        m_nxt[c] = load_half; m_pend[c] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    e = '{err: m_err, pend: m_pend, clk: m_clk, tck: m_tick};
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    e = sb_q.pop_front();
    check("load_err", 32'(load_err), 32'(e.err));
    check("pending",  32'(pending),  32'(e.pend));
    check("clk_out",  32'(clk_out),  32'(e.clk));
    check("tick",     32'(tick),     32'(e.tck));
  endtask

  task automatic wait_rise(input int ch, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick[ch] && n < 100);
    if (!tick[ch]) check("wait_rise_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; en = 2'b00; load = 1'b0; load_ch = 1'b0; load_half = 8'd0;
    en3 = 3'b000; load3 = 1'b0; load_ch3 = 2'd0; load_half3 = 8'd0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_err",     32'(load_err), 32'd0);

    // Default operation: period 8 on both channels.
    reset = 1'b0; en = 2'b11;
    wait_rise(0, n); check("first_rise_ch0", 32'(n), 32'd4);
    check("first_rise_ch1", 32'(tick[1]), 32'd1);
    wait_rise(0, n); check("period8_ch0", 32'(n), 32'd8);

    // Reload ch0 to H=2 in the first high cycle.
    load = 1'b1; load_ch = 1'b0; load_half = 8'd2;
    cycle();
    load = 1'b0;
    check("pend_after_load", 32'(pending), 32'b01);
    wait_rise(0, n); check("reload_rise_ch0", 32'(n + 1), 32'd6);
    wait_rise(0, n); check("period4_ch0", 32'(n), 32'd4);

    // Rejected loads: zero half, and out-of-range channel on the 3-channel unit.
    load = 1'b1; load_ch = 1'b0; load_half = 8'd0;
    load3 = 1'b1; load_ch3 = 2'd3; load_half3 = 8'd5;
    cycle();
    check("err_zero", 32'(load_err), 32'd1);
    check("err_ch3", 32'(load_err3), 32'd1);
    check("err_ch3_pend", 32'(pending3), 32'd0);
    load_ch = 1'b1; load_ch3 = 2'd2;
    cycle();
    check("err_zero_ch1", 32'(load_err), 32'd1);
    check("ok_ch2_err", 32'(load_err3), 32'd0);
    check("ok_ch2_pend", 32'(pending3), 32'b100);
    load = 1'b0; load3 = 1'b0;
    cycle();
    check("err_cleared", 32'(load_err), 32'd0);

    // ch1: load 1 on a wrap edge, overwrite with 3 before the next wrap.
    wait_rise(1, n);
    repeat (3) cycle();
    load = 1'b1; load_ch = 1'b1; load_half = 8'd1;
    cycle();
    load_half = 8'd3;
    cycle();
    load = 1'b0;
    wait_rise(1, n); check("last_write_rise", 32'(n), 32'd3);
    wait_rise(1, n); check("period6_ch1", 32'(n), 32'd6);

    // ch0 disabled with pending 5, then re-enabled.
    load = 1'b1; load_ch = 1'b0; load_half = 8'd5;
    cycle();
    load = 1'b0; en[0] = 1'b0;
    cycle();
    check("dis_clk0", 32'(clk_out[0]), 32'd0);
    check("dis_pend0", 32'(pending[0]), 32'd0);
    repeat (2) cycle();
    en[0] = 1'b1;
    wait_rise(0, n); check("reen_rise_ch0", 32'(n), 32'd5);
    wait_rise(0, n); check("period10_ch0", 32'(n), 32'd10);

    // Asynchronous reset in a high phase.
    wait_rise(1, n);
    #2 reset = 1'b1;
    #1;
    check("async_rst_clk", 32'(clk_out), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_pend", 32'(pending), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1 reset = 1'b0;
    wait_rise(0, n); check("post_rst_rise", 32'(n), 32'd4);
    wait_rise(0, n); check("post_rst_p8_ch0", 32'(n), 32'd8);
    check("post_rst_tick_ch1", 32'(tick[1]), 32'd1);
    wait_rise(1, n); check("post_rst_p8_ch1", 32'(n), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
